// File: rtl/result_deskew.sv
// result_deskew: realigns the staggered result lanes of the systolic array into whole rows
// and buffers them in a first-word-fall-through FIFO. Define RESULT_DESKEW_MISALIGN_CHECK_EN to flag partial rows.
module result_deskew #(
    parameter int WIDTH      = 32,
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ROWS       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES-1:0]              in_valid,
    input  logic [LANES*WIDTH-1:0]        in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*WIDTH-1:0]        out_data,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          misalign
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

    logic [LANES-1:0]       dly_vld;
    logic [LANES*WIDTH-1:0] dly_dat;

    // Stage p0: per-lane delay lines, lane i delayed by LANES-1-i cycles
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int D = LANES - 1 - gi;
            if (D == 0) begin : g_direct
                assign dly_vld[gi] = in_valid[gi];
                assign dly_dat[gi*WIDTH +: WIDTH] = in_valid[gi] ? in_data[gi*WIDTH +: WIDTH] : '0;
            end else begin : g_delay
                logic [D-1:0]     vld_p0;
                logic [WIDTH-1:0] dat_p0 [D];

                always_ff @(posedge clk) begin
                    if (!rst) begin
                        vld_p0 <= '0;
                        for (int s = 0; s < D; s++) begin
                            dat_p0[s] <= '0;
                        end
                    end else begin
                        vld_p0[0] <= in_valid[gi];
                        dat_p0[0] <= in_valid[gi] ? in_data[gi*WIDTH +: WIDTH] : '0;
                        for (int s = 1; s < D; s++) begin
                            vld_p0[s] <= vld_p0[s-1];
                            dat_p0[s] <= dat_p0[s-1];
                        end
                    end
                end

                assign dly_vld[gi] = vld_p0[D-1];
                assign dly_dat[gi*WIDTH +: WIDTH] = dat_p0[D-1];
            end
        end
    endgenerate

    // Stage p1: aligned row register
    logic [LANES-1:0]       row_vld_p1;
    logic [LANES*WIDTH-1:0] row_dat_p1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_vld_p1 <= '0;
            row_dat_p1 <= '0;
        end else begin
            row_vld_p1 <= dly_vld;
            row_dat_p1 <= dly_dat;
        end
    end

    logic all_vld;
    assign all_vld = &row_vld_p1;

    // Stage p2: output FIFO
    logic [LANES*WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          row_cnt;
    logic                   empty;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   overflow_r;

    assign empty     = (level == '0);
    assign full      = (level == FULL_LVL);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a row when the head leaves in the same cycle
    assign push      = all_vld && (!full || pop);
    assign drop      = all_vld && full && !pop;
    assign out_data  = empty ? '0 : mem[rd_ptr];
    assign out_last  = out_valid && (row_cnt == LAST_ROW);
    assign overflow  = overflow_r;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= row_dat_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            row_cnt    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                if (row_cnt == LAST_ROW) begin
                    row_cnt <= '0;
                end else begin
                    row_cnt <= row_cnt + CW'(1);
                end
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow_r <= 1'b1;
            end
        end
    end

`ifdef RESULT_DESKEW_MISALIGN_CHECK_EN
    logic part_vld;
    logic misalign_r;

    assign part_vld = (|row_vld_p1) && !all_vld;
    assign misalign = misalign_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_r <= 1'b0;
        end else if (part_vld) begin
            misalign_r <= 1'b1;
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_result_deskew.sv
// Randomized scoreboard bench for result_deskew: a row-level queue model fed from the sampled pins.
module tb_result_deskew;
    localparam int WIDTH      = 32;
    localparam int LANES      = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int ROWS       = 4;
    localparam int DW         = LANES * WIDTH;
    localparam int NSLOT      = 64;
`ifdef RESULT_DESKEW_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic                           clk = 1'b0;
    logic                           rst = 1'b0;
    logic [LANES-1:0]               in_valid = '0;
    logic [DW-1:0]                  in_data = '0;
    logic                           out_valid;
    logic                           out_ready = 1'b0;
    logic [DW-1:0]                  out_data;
    logic                           out_last;
    logic [$clog2(FIFO_DEPTH):0]    level;
    logic                           overflow;
    logic                           misalign;

    always #5 clk = ~clk;

    result_deskew #(
        .WIDTH(WIDTH), .LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH), .ROWS(ROWS)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .level(level), .overflow(overflow), .misalign(misalign)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle input schedule; slot k is driven just after the k-th rising edge
    logic [LANES-1:0] slot_v [NSLOT];
    logic [DW-1:0]    slot_d [NSLOT];
    int cyc = 0;

    initial begin
        for (int k = 0; k < NSLOT; k++) begin
            slot_v[k] = '0;
            slot_d[k] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            in_valid = slot_v[cyc % NSLOT];
            in_data  = slot_d[cyc % NSLOT];
            slot_v[cyc % NSLOT] = '0;
            slot_d[cyc % NSLOT] = '0;
            cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Lane i of the row is presented i cycles after lane 0; late_lane arrives one extra cycle late
    task automatic sched_row(input int dly, input logic [DW-1:0] row, input int late_lane);
        int s;
        for (int i = 0; i < LANES; i++) begin
            s = (cyc + dly + i + ((i == late_lane) ? 1 : 0)) % NSLOT;
            slot_v[s][i] = 1'b1;
            slot_d[s][i*WIDTH +: WIDTH] = row[i*WIDTH +: WIDTH];
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    function automatic logic [DW-1:0] mk_row(input int base);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) begin
            r[i*WIDTH +: WIDTH] = WIDTH'(base + i);
        end
        return r;
    endfunction

    // Reference model: a row written at edge e takes lane i as sampled at edge e-LANES+i
    typedef struct packed {
        logic [LANES-1:0] v;
        logic [DW-1:0]    d;
    } samp_t;

    samp_t         hist[$];
    logic [DW-1:0] exp_q[$];
    int            pop_cnt = 0;
    bit            exp_ovf = 1'b0;
    bit            exp_mis = 1'b0;
    bit            started = 1'b0;

    initial begin
        logic [LANES-1:0] av;
        logic [DW-1:0]    ad;
        samp_t            cur;
        bit               pop;
        forever begin
            @(posedge clk);
            if (!rst) begin
                exp_q.delete();
                hist.delete();
                for (int j = 0; j < LANES; j++) hist.push_back('0);
                pop_cnt = 0;
                exp_ovf = 1'b0;
                exp_mis = 1'b0;
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    av[i] = hist[LANES-1-i].v[i];
                    ad[i*WIDTH +: WIDTH] = av[i] ? hist[LANES-1-i].d[i*WIDTH +: WIDTH] : '0;
                end
                pop = (exp_q.size() != 0) && out_ready;
                if (pop) begin
                    void'(exp_q.pop_front());
                    pop_cnt++;
                end
                if (&av) begin
                    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(ad);
                    else exp_ovf = 1'b1;
                end else if ((|av) && MIS_EN) begin
                    exp_mis = 1'b1;
                end
                cur.v = in_valid;
                cur.d = in_data;
                hist.push_front(cur);
                void'(hist.pop_back());
            end
            started = 1'b1;
        end
    end

    // Monitor: compares every DUT output against the model on the falling edge
    initial begin
        bit            ev;
        logic [DW-1:0] ed;
        forever begin
            @(negedge clk);
            if (started) begin
                ev = (exp_q.size() != 0);
                ed = ev ? exp_q[0] : '0;
                chk("out_valid", DW'(out_valid), DW'(ev));
                chk("level", DW'(level), DW'(exp_q.size()));
                chk("out_data", out_data, ed);
                chk("out_last", DW'(out_last), DW'(ev && (pop_cnt % ROWS == ROWS - 1)));
                chk("overflow", DW'(overflow), DW'(exp_ovf));
                chk("misalign", DW'(misalign), DW'(exp_mis));
            end
        end
    end

    initial begin
        rst = 1'b0;
        out_ready = 1'b0;
        step(1);
        for (int k = 0; k < 3; k++) begin
            slot_v[(cyc + k) % NSLOT] = LANES'($urandom);
            slot_d[(cyc + k) % NSLOT] = {$urandom, $urandom, $urandom, $urandom};
        end
        out_ready = 1'b1;
        step(4);
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_level", DW'(level), '0);
        chk("rst_overflow", DW'(overflow), '0);
        chk("rst_misalign", DW'(misalign), '0);
        chk("rst_out_data", out_data, '0);
        rst = 1'b1;
        out_ready = 1'b0;
        step(4);

        // Single row: exact latency and lane packing
        sched_row(0, mk_row(32'h10), -1);
        step(5);
        chk("lat_not_yet", DW'(out_valid), '0);
        step(1);
        chk("lat_valid", DW'(out_valid), DW'(1));
        chk("single_data", out_data, {32'h13, 32'h12, 32'h11, 32'h10});
        chk("single_level", DW'(level), DW'(1));
        out_ready = 1'b1;
        step(1);
        chk("single_pop", DW'(level), '0);

        // Tile framing: five back-to-back rows with out_ready held
        do_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 5; r++) sched_row(r, mk_row(32'h100 * (r + 1)), -1);
        step(14);

        // Full FIFO with a push coinciding with a pop
        do_reset();
        out_ready = 1'b0;
        for (int r = 0; r < FIFO_DEPTH; r++) sched_row(r, mk_row(32'h200 + 16 * r), -1);
        step(FIFO_DEPTH + 8);
        chk("full_level", DW'(level), DW'(FIFO_DEPTH));
        sched_row(0, mk_row(32'h2F0), -1);
        step(5);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("pushpop_level", DW'(level), DW'(FIFO_DEPTH));
        chk("pushpop_overflow", DW'(overflow), '0);
        out_ready = 1'b1;
        step(FIFO_DEPTH + 3);

        // Overflow: nine rows into eight entries, drain in order
        do_reset();
        out_ready = 1'b0;
        for (int r = 0; r < FIFO_DEPTH + 1; r++) sched_row(r, mk_row((r + 1) * 16), -1);
        step(FIFO_DEPTH + 10);
        chk("ovf_level", DW'(level), DW'(FIFO_DEPTH));
        chk("ovf_flag", DW'(overflow), DW'(1));
        out_ready = 1'b1;
        for (int k = 1; k <= FIFO_DEPTH; k++) begin
            chk("drain_row", DW'(out_data[WIDTH-1:0]), DW'(k * 16));
            step(1);
        end
        chk("drain_empty", DW'(out_valid), '0);

        // Misalign: lane 2 one cycle late
        do_reset();
        out_ready = 1'b0;
        sched_row(0, mk_row(32'h300), 2);
        step(10);
        chk("mis_flag", DW'(misalign), DW'(MIS_EN));
        chk("mis_level", DW'(level), '0);

        // Randomized traffic
        do_reset();
        for (int it = 0; it < 300; it++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
                sched_row(0, {$urandom, $urandom, $urandom, $urandom},
                          ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LANES - 1)) : -1);
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(1);
        end
        out_ready = 1'b1;
        step(FIFO_DEPTH + 10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
